// File: rtl/rf_1r1w_arb_pkg.sv
// Shared constants for the rf_1r1w bank arbiter: requester index width and
// the default write-starvation limit.
package rf_1r1w_arb_pkg;
  localparam int ID_W           = 1;
  localparam int STARVE_MAX_DEF = 3;
endpackage

// File: rtl/rf_1r1w_arb_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the preferred requester and
// flips away from whoever was last granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic rr;

  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      if (req == 2'b11) gnt = rr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  rr <= 1'b0;
    else if (|gnt) rr <= ~gnt[1];
  end
endmodule

// File: rtl/rf_1r1w_arb.sv
// Arbiter/sequencer for one 1R1W register-file bank: round-robin read port,
// priority write port with a starvation guard, and same-cycle write bypass.
module rf_1r1w_arb
  import rf_1r1w_arb_pkg::*;
#(
  parameter int WIDTH      = 65,
  parameter int LG_DEPTH   = 8,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          rd_val,
  input  logic [LG_DEPTH-1:0] rd_addr0,
  input  logic [LG_DEPTH-1:0] rd_addr1,
  output logic [1:0]          rd_rdy,
  input  logic [1:0]          wr_val,
  input  logic [LG_DEPTH-1:0] wr_addr0,
  input  logic [LG_DEPTH-1:0] wr_addr1,
  input  logic [WIDTH-1:0]    wr_data0,
  input  logic [WIDTH-1:0]    wr_data1,
  output logic [1:0]          wr_rdy,
  output logic                resp_val,
  output logic [ID_W-1:0]     resp_id,
  output logic [WIDTH-1:0]    resp_data,
  output logic                rf_ren,
  output logic [LG_DEPTH-1:0] rf_raddr,
  input  logic [WIDTH-1:0]    rf_rdata,
  output logic                rf_wen,
  output logic [LG_DEPTH-1:0] rf_waddr,
  output logic [WIDTH-1:0]    rf_wdata
);
  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]     starve;
  logic              vld_p1;
  logic [ID_W-1:0]   id_p1;
  logic              byp_p1;
  logic [WIDTH-1:0]  byp_data_p1;

  // ---- stage p0: arbitration and bank issue ----
  rr_arb2 u_rd_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (rd_val),
    .gnt     (rd_rdy)
  );

  assign rf_ren   = |rd_rdy;
  assign rf_raddr = rd_rdy[1] ? rd_addr1 : rd_addr0;

  // Requester 0 has priority unless requester 1 has lost STARVE_MAX times in a row.
  always_comb begin
    wr_rdy = 2'b00;
    if (reset_n) begin
      if (wr_val[1] && (!wr_val[0] || starve == STARVE_LIM)) wr_rdy = 2'b10;
      else if (wr_val[0])                                    wr_rdy = 2'b01;
    end
  end

  assign rf_wen   = |wr_rdy;
  assign rf_waddr = wr_rdy[1] ? wr_addr1 : wr_addr0;
  assign rf_wdata = wr_rdy[1] ? wr_data1 : wr_data0;

  always_ff @(posedge clk) begin
    if (!reset_n)                     starve <= '0;
    else if (wr_rdy[1] || !wr_val[1]) starve <= '0;
    else if (wr_val == 2'b11)         starve <= starve + SW'(1);
  end

  // ---- stage p1: response ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
      byp_p1 <= 1'b0;
    end else begin
      vld_p1 <= rf_ren;
      id_p1  <= ID_W'(rd_rdy[1]);
      byp_p1 <= rf_ren && rf_wen && (rf_raddr == rf_waddr);
    end
  end

  always_ff @(posedge clk) begin
    byp_data_p1 <= rf_wdata;
  end

  assign resp_val  = vld_p1;
  assign resp_id   = id_p1;
  assign resp_data = byp_p1 ? byp_data_p1 : rf_rdata;
endmodule
